// File: rtl/branch_pkg.sv
// ---------------------------------------------------------------------------
// branch_pkg
// Shared types and constants for the program-sequencing stage.
//   cond_e  : branch condition codes evaluated against the {c,n,z} flags
//   state_e : sequencer control states (IDLE, RUN, HALTED)
//   FLAG_*  : bit positions of carry, negative and zero inside a flag vector
// ---------------------------------------------------------------------------
package branch_pkg;

  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_Z = 0;

  typedef enum logic [2:0] {
    COND_AL = 3'b000,
    COND_EQ = 3'b001,
    COND_NE = 3'b010,
    COND_MI = 3'b011,
    COND_PL = 3'b100,
    COND_CS = 3'b101,
    COND_CC = 3'b110,
    COND_NV = 3'b111
  } cond_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    HALTED = 2'b10
  } state_e;

endpackage

// File: rtl/branch_cond_eval.sv
// ---------------------------------------------------------------------------
// branch_cond_eval
// Purely combinational condition-code evaluator, shared with the decoder.
// Ports:
//   flags_i     : {c,n,z} flag vector to test
//   cond_i      : condition code (cond_e)
//   cond_true_o : 1 when the condition holds for flags_i
// ---------------------------------------------------------------------------
module branch_cond_eval
  import branch_pkg::*;
(
  input  logic [2:0] flags_i,
  input  cond_e      cond_i,
  output logic       cond_true_o
);

  // Decode the condition code into a test on one flag bit (or a constant
  // for always/never). The default keeps the block latch-free.
  always_comb begin
    cond_true_o = 1'b0;
    case (cond_i)
      COND_AL: cond_true_o = 1'b1;
      COND_EQ: cond_true_o = flags_i[FLAG_Z];
      COND_NE: cond_true_o = ~flags_i[FLAG_Z];
      COND_MI: cond_true_o = flags_i[FLAG_N];
      COND_PL: cond_true_o = ~flags_i[FLAG_N];
      COND_CS: cond_true_o = flags_i[FLAG_C];
      COND_CC: cond_true_o = ~flags_i[FLAG_C];
      COND_NV: cond_true_o = 1'b0;
      default: cond_true_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/pc_branch_unit.sv
// ---------------------------------------------------------------------------
// pc_branch_unit
// Program-sequencing stage behind the 8-bit ALU: flag register, carry
// feedback, conditional branch resolution, program counter and a
// start/halt/done control FSM with a saturating run-cycle counter.
//
// Optional build macro: FLAG_BYPASS_EN
//   When defined, a flag write in RUN forwards flags_in_i straight into the
//   condition evaluation so a compare and its dependent branch can resolve
//   in the same cycle. The flag register and cin_o are unaffected.
//
// Ports:
//   clk_i, reset_i      : clock, asynchronous active-high reset
//   start_i/start_addr_i: begin execution at start_addr_i (IDLE/HALTED only)
//   flags_in_i, flag_we_i: ALU flags {c,n,z} and their write enable
//   branch_*_i          : branch enable, condition, abs/rel select, offset
//   halt_req_i          : current instruction is HALT
//   pc_o                : program counter
//   cin_o, flags_q_o    : registered carry and registered flags
//   taken_o             : branch taken this cycle (combinational)
//   busy_o, done_o      : registered RUN / HALTED indications
//   cycle_count_o       : saturating RUN-cycle counter since last start
// ---------------------------------------------------------------------------
module pc_branch_unit
  import branch_pkg::*;
#(
  parameter int PC_W  = 10,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [PC_W-1:0]  start_addr_i,
  input  logic [2:0]       flags_in_i,
  input  logic             flag_we_i,
  input  logic             branch_en_i,
  input  logic [2:0]       branch_cond_i,
  input  logic             branch_abs_i,
  input  logic [7:0]       branch_off_i,
  input  logic             halt_req_i,
  output logic [PC_W-1:0]  pc_o,
  output logic             cin_o,
  output logic [2:0]       flags_q_o,
  output logic             taken_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] cycle_count_o
);

  state_e           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [2:0]       flags_q, flags_d;
  logic [CNT_W-1:0] cycleCount_q, cycleCount_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             inRun;
  logic [2:0]       condFlags;
  logic             condTrue;
  logic [PC_W-1:0]  offRel;
  logic [PC_W-1:0]  offAbs;
  logic [PC_W-1:0]  target;

  assign inRun = (state_q == RUN);

`ifdef FLAG_BYPASS_EN
  // Forward the flags being written this cycle so the branch sees them now.
  assign condFlags = (flag_we_i && inRun) ? flags_in_i : flags_q;
`else
  // Branches see the flag register, one instruction behind a flag write.
  assign condFlags = flags_q;
`endif

  branch_cond_eval u_cond_eval (
    .flags_i     (condFlags),
    .cond_i      (cond_e'(branch_cond_i)),
    .cond_true_o (condTrue)
  );

  // The size casts sign-extend the relative offset and zero-extend the
  // absolute target; both simply truncate if PC_W is narrower than 8.
  assign offRel = PC_W'($signed(branch_off_i));
  assign offAbs = PC_W'(branch_off_i);
  assign target = branch_abs_i ? offAbs : (pc_q + offRel);

  // A halting instruction never branches, even if its branch bits are set.
  assign taken_o = branch_en_i & condTrue & inRun & ~halt_req_i;

  // Next-state logic for the sequencer. IDLE and HALTED behave identically
  // apart from what done reports; RUN gives halt priority over a taken
  // branch, which in turn beats the plain increment. The flag register and
  // the cycle counter only move while running.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    flags_d      = flags_q;
    cycleCount_d = cycleCount_q;

    case (state_q)
      IDLE, HALTED: begin
        if (start_i) begin
          pc_d         = start_addr_i;
          cycleCount_d = '0;
          state_d      = RUN;
        end
      end
      RUN: begin
        if (flag_we_i) begin
          flags_d = flags_in_i;
        end
        if (cycleCount_q != '1) begin
          cycleCount_d = cycleCount_q + CNT_W'(1);
        end
        if (halt_req_i) begin
          state_d = HALTED;
        end else if (taken_o) begin
          pc_d = target;
        end else begin
          pc_d = pc_q + PC_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN);
    done_d = (state_d == HALTED);
  end

  // Single state register for the whole sequencer, including the registered
  // busy/done outputs so they change together with the state.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      pc_q         <= '0;
      flags_q      <= '0;
      cycleCount_q <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      flags_q      <= flags_d;
      cycleCount_q <= cycleCount_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign pc_o          = pc_q;
  assign flags_q_o     = flags_q;
  assign cin_o         = flags_q[FLAG_C];
  assign cycle_count_o = cycleCount_q;
  assign busy_o        = busy_q;
  assign done_o        = done_q;

endmodule
